// File: rtl/uart_packet_framer.sv
// uart_packet_framer
// Collects a payload from a valid/ready producer into an internal buffer, then
// emits SOF, LEN, payload[, CHK] to the UART TX stage's byte-strobe interface,
// pacing each strobe against the TX stage's buffer-full flag.
// Optional feature macro: FRAMER_CHECKSUM_EN (adds the CHK word and checksum
// accumulator; when undefined, the payload is followed directly by DONE).
`default_nettype none

module uart_packet_framer #(
  parameter int          BIT_PER_WORD = 7,
  parameter int          MAX_LEN      = 16,
  parameter int unsigned SOF_WORD     = 32'hA5,
  parameter int          STROBE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIT_PER_WORD:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [BIT_PER_WORD:0] tx_data,
  output logic                  tx_strobe,
  input  logic                  tx_full,
  output logic                  pkt_done,
  output logic                  overflow,
  output logic                  frame_busy,
  output logic [2:0]            state_out
);

  localparam int W  = BIT_PER_WORD + 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = $clog2(STROBE_GAP);

  localparam logic [W-1:0]  SOF_W    = W'(SOF_WORD);
  localparam logic [W-1:0]  MAX_W    = W'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LAST = GW'(STROBE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    SEND_SOF = 3'd2,
    SEND_LEN = 3'd3,
    SEND_PAY = 3'd4,
    SEND_CHK = 3'd5,
    DONE     = 3'd6
  } state_e;

  state_e        state_q;
  logic [W-1:0]  count_q;
  logic [W-1:0]  count_d;
  logic [W-1:0]  rd_q;
  logic          sent_q;
  logic [GW-1:0] gap_q;
  logic [W-1:0]  tx_data_q;
  logic          tx_strobe_q;
  logic          in_ready_q;
  logic          pkt_done_q;
  logic          overflow_q;
  logic [W-1:0]  buf_q [MAX_LEN];
  logic [W-1:0]  send_word;
  logic          accept;

`ifdef FRAMER_CHECKSUM_EN
  logic [W-1:0]  chk_q;
`endif

  // A word is taken only when the registered ready is up (IDLE/COLLECT only).
  assign accept  = in_valid && in_ready_q;
  assign count_d = count_q + W'(1);

  // Payload storage; IDLE always has count_q==0, so count_q is the write slot.
  always_ff @(posedge clk) begin
    if (accept) buf_q[count_q[IW-1:0]] <= in_data;
  end

`ifdef FRAMER_CHECKSUM_EN
  // Running payload sum; cleared between packets so IDLE starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= chk_q + in_data;
    end else if (state_q == DONE) begin
      chk_q <= '0;
    end
  end
`endif

  // Word presented to the TX stage in the current SEND_* state.
  always_comb begin
    send_word = '0;
    case (state_q)
      SEND_SOF: send_word = SOF_W;
      SEND_LEN: send_word = count_q;
      SEND_PAY: send_word = buf_q[rd_q[IW-1:0]];
`ifdef FRAMER_CHECKSUM_EN
      // LEN + payload + CHK sums to zero modulo 2^W.
      SEND_CHK: send_word = W'(0) - (count_q + chk_q);
`endif
      default:  send_word = '0;
    endcase
  end

  // Framer FSM: collection, paced strobe sequencing and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_q        <= '0;
      sent_q      <= 1'b0;
      gap_q       <= '0;
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
      in_ready_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tx_strobe_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            count_q <= count_d;
            if (in_last || (count_d == MAX_W)) begin
              state_q    <= SEND_SOF;
              in_ready_q <= 1'b0;
              // Buffer filled without seeing the end of the payload.
              if (!in_last) overflow_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end

        SEND_SOF, SEND_LEN, SEND_PAY, SEND_CHK: begin
          if (!sent_q) begin
            // tx_full is only consulted before launching a strobe.
            if (!tx_full) begin
              tx_data_q   <= send_word;
              tx_strobe_q <= 1'b1;
              sent_q      <= 1'b1;
              gap_q       <= GW'(1);
            end
          end else if (gap_q == GAP_LAST) begin
            // Gap elapsed: the next state may strobe on the following edge.
            sent_q <= 1'b0;
            gap_q  <= '0;
            case (state_q)
              SEND_SOF: state_q <= SEND_LEN;
              SEND_LEN: begin
                state_q <= SEND_PAY;
                rd_q    <= '0;
              end
              SEND_PAY: begin
                if (rd_q == (count_q - W'(1))) begin
                  rd_q <= '0;
`ifdef FRAMER_CHECKSUM_EN
                  state_q <= SEND_CHK;
`else
                  state_q    <= DONE;
                  pkt_done_q <= 1'b1;
`endif
                end else begin
                  rd_q <= rd_q + W'(1);
                end
              end
              default: begin
                state_q    <= DONE;
                pkt_done_q <= 1'b1;
              end
            endcase
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        DONE: begin
          state_q    <= IDLE;
          count_q    <= '0;
          in_ready_q <= 1'b1;
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_strobe  = tx_strobe_q;
  assign pkt_done   = pkt_done_q;
  assign overflow   = overflow_q;
  assign frame_busy = (state_q != IDLE);
  assign state_out  = state_q;

endmodule

`default_nettype wire

// File: doc/uart_packet_framer.md
Name: uart_packet_framer

Overview:
- Upstream feeder for the UART transmit stage.
- Collects a payload from a producer over a valid/ready handshake and stores it in an internal buffer.
- Emits a framed packet to the TX stage's byte-strobe interface: SOF, LEN, payload, CHK.
- Paces every strobe against the TX stage's buffer-full flag so no byte is ever dropped.

Parameters:
- BIT_PER_WORD, 7: MSB index of a word; word width W = BIT_PER_WORD+1.
- MAX_LEN, 16: payload buffer depth in words. Range 1..2^W-1.
- SOF_WORD, 8'hA5: start-of-frame word, truncated to W bits.
- STROBE_GAP, 4: clocks from one tx_strobe rising edge to the earliest next one. Minimum 4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  W  payload word from producer.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies in_data as the final payload word.
- in_ready  out  1  framer accepts a word this cycle.
- tx_data  out  W  word to TX stage dataIn.
- tx_strobe  out  1  to TX stage data_clk; the TX stage writes on its rising edge.
- tx_full  in  1  TX stage busy (buffer full).
- pkt_done  out  1  one-clock pulse after the last frame word is strobed.
- overflow  out  1  sticky; set when the payload was truncated at MAX_LEN.
- frame_busy  out  1  high in any state other than IDLE.
- state_out  out  3  current state encoding, for debug.

Behaviour:
- Reset (async assert, sync release) clears everything:
  - tx_strobe=0, tx_data=0, in_ready=0, pkt_done=0, overflow=0, frame_busy=0.
  - state=IDLE, count=0, checksum=0.
  - A reset mid-frame abandons the frame. Words already strobed remain in the TX stage; no recovery.
- States (encoding): IDLE=0, COLLECT=1, SEND_SOF=2, SEND_LEN=3, SEND_PAY=4, SEND_CHK=5, DONE=6.
- IDLE:
  - in_ready=1.
  - On in_valid: store word at index 0, count<=1, checksum<=in_data, go to COLLECT.
  - If in_last is also set, go to SEND_SOF instead.
- COLLECT:
  - in_ready=1.
  - Each in_valid stores the word at index count, count++, checksum+=in_data (mod 2^W).
  - Go to SEND_SOF on in_last, or when the stored word makes count==MAX_LEN. In the MAX_LEN case with in_last=0, set overflow=1.
  - in_ready is low in every other state.
- Send sub-sequence, used by each SEND_* state:
  - (a) Wait until tx_full==0.
  - (b) Drive tx_data, and set tx_strobe=1 for exactly one clock.
  - (c) Hold tx_data stable and tx_strobe=0 until STROBE_GAP clocks have elapsed since (b), so the TX stage's one-cycle-delayed write and full update have settled.
  - (d) Advance.
  - tx_full is sampled only in (a).
- Word sent per state:
  - SEND_SOF: SOF_WORD.
  - SEND_LEN: count (LEN word).
  - SEND_PAY: buffer[0..count-1] in order; read index advances after each (c).
  - SEND_CHK: (0 - (count + checksum)) mod 2^W, so LEN + payload + CHK ≡ 0 mod 2^W.
- DONE: pkt_done=1 for one clock, then IDLE. count and checksum clear.
- Boundaries:
  - tx_full held high stalls indefinitely in (a), with no timeout.
  - MAX_LEN=1: the first word always ends collection.
  - Payload extra to MAX_LEN is not accepted. The producer sees in_ready=0 until the next IDLE.
  - overflow clears only on reset.

Optional Feature:
- Macro FRAMER_CHECKSUM_EN.
- Defined: SEND_CHK is present as above.
- Undefined: SEND_PAY goes directly to DONE. No CHK word is sent, and the checksum accumulator is not synthesised.

Test Plan:
- Producer sends 01,02,03 (last on 03), tx_full=0 -> tx strobes A5,03,01,02,03,F7. Rising edges ≥4 clocks apart. pkt_done pulses once.
- Single word 7F with in_last -> A5,01,7F,80. Feature undefined: A5,01,7F.
- 17 words, no in_last, MAX_LEN=16 -> 16 accepted, LEN=10, overflow=1, in_ready=0 until IDLE.
- tx_full forced high before the LEN strobe for 50 clocks -> no strobe during the stall. The LEN strobe follows ≤1 clock after release, and the sequence completes intact.
- rst_n low mid-payload -> all outputs zero asynchronously. A new packet after release frames correctly from SOF.
- Back-to-back packets, in_valid held high -> the second packet is accepted only after pkt_done, with no interleaved words.
